// File: rtl/seq_det_pkg.sv
// Shared helpers for serial pattern detectors: state encoding for the default
// 4-bit case, width helper, and the elaboration-time KMP next-prefix function.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Longest prefix of pat (first bit = pat[n-1]) that is a suffix of the
    // first k pattern bits followed by x, capped below n so a full match
    // folds back onto its longest proper border.
    function automatic int next_prefix(input logic [15:0] pat, input int n,
                                       input int k, input logic x,
                                       input logic overlap);
        logic [16:0] txt;
        int          m;
        int          best;
        logic        ok;
        if (k == n - 1 && x == pat[0] && !overlap) return 0;
        txt  = '0;
        best = 0;
        for (int i = 0; i < k; i++) txt[i] = pat[n - 1 - i];
        txt[k] = x;
        m = k + 1;
        for (int l = 1; l <= m && l < n; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++)
                if (txt[m - l + j] != pat[n - 1 - j]) ok = 1'b0;
            if (ok) best = l;
        end
        return best;
    endfunction

endpackage

// File: rtl/mealy_seq.sv
// Serial Mealy sequence detector; z flags the cycle whose x completes PATTERN.
// Transitions come from a table of constants built at elaboration.
module mealy_seq
    import seq_det_pkg::*;
#(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1001,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic x,
    output logic z
);

    localparam int              SW    = clog2_min1(N);
    localparam int              NS    = 1 << SW;
    localparam logic [15:0]     PAT16 = 16'(PATTERN);
    localparam logic [SW-1:0]   LAST  = SW'(N - 1);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] nxt0_tbl [NS];
    logic [SW-1:0] nxt1_tbl [NS];

    // Encodings at or above N are unreachable and fall back to S0.
    for (genvar gi = 0; gi < NS; gi++) begin : g_tbl
        if (gi < N) begin : g_valid
            localparam int NXT0 = next_prefix(PAT16, N, gi, 1'b0, OVERLAP);
            localparam int NXT1 = next_prefix(PAT16, N, gi, 1'b1, OVERLAP);
            assign nxt0_tbl[gi] = NXT0[SW-1:0];
            assign nxt1_tbl[gi] = NXT1[SW-1:0];
        end else begin : g_illegal
            assign nxt0_tbl[gi] = '0;
            assign nxt1_tbl[gi] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= '0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = x ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
    end

    always_comb begin
        z = reset && (state_q == LAST) && (x == PATTERN[0]);
    end

endmodule

// File: tb/tb_mealy_seq.sv
// Directed bench for mealy_seq: overlapping and non-overlapping instances
// share one stream; z is checked combinationally before each capturing edge.
module tb_mealy_seq;

    logic clock;
    logic reset;
    logic x;
    logic z_ov;
    logic z_no;
    int   total;
    int   bad;

    mealy_seq u_ov (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .z     (z_ov)
    );

    mealy_seq #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0)) u_no (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .z     (z_no)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive x mid-cycle (after the falling edge) and let it settle.
    task automatic drive_bit(input logic b);
        @(negedge clock);
        x = b;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        // Reach S3 first so the forced-zero check is meaningful.
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            x = 1'b1; #1;
            total++;
            if (z_ov !== 1'b0 || z_no !== 1'b0) begin
                bad++;
                $display("FAIL reset_force c=%0d x=1 z_ov=%b z_no=%b expected 0", c, z_ov, z_no);
            end
            x = 1'b0; #1;
            total++;
            if (z_ov !== 1'b0 || z_no !== 1'b0) begin
                bad++;
                $display("FAIL reset_force c=%0d x=0 z_ov=%b z_no=%b expected 0", c, z_ov, z_no);
            end
            @(negedge clock);
        end
        reset = 1'b1;
        drive_bit(1'b1);
        total++;
        if (z_ov !== 1'b0 || z_no !== 1'b0) begin
            bad++;
            $display("FAIL reset_release z_ov=%b z_no=%b expected 0", z_ov, z_no);
        end
        $display("test_reset: reset held 2 edges, release x=1 z_ov=%b z_no=%b", z_ov, z_no);
    endtask

    task automatic test_canonical();
        logic [12:0] bits;
        logic [12:0] exp_ov;
        logic [12:0] exp_no;
        bits   = 13'b1001001100100;
        exp_ov = 13'b0001001000100;
        exp_no = 13'b0001000000100;
        pulse_reset();
        for (int i = 12; i >= 0; i--) begin
            drive_bit(bits[i]);
            total++;
            if (z_ov !== exp_ov[i] || z_no !== exp_no[i]) begin
                bad++;
                $display("FAIL canonical bit%0d z_ov=%b z_no=%b expected %b/%b",
                         13 - i, z_ov, z_no, exp_ov[i], exp_no[i]);
            end
            $display("canonical bit%0d x=%b z_ov=%b z_no=%b", 13 - i, bits[i], z_ov, z_no);
        end
    endtask

    task automatic test_mealy_timing();
        pulse_reset();
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        @(negedge clock);
        x = 1'b0; #1;
        total++;
        if (z_ov !== 1'b0) begin
            bad++;
            $display("FAIL mealy_x0a z=%b expected 0", z_ov);
        end
        x = 1'b1; #1;
        total++;
        if (z_ov !== 1'b1 || z_no !== 1'b1) begin
            bad++;
            $display("FAIL mealy_x1 z_ov=%b z_no=%b expected 1", z_ov, z_no);
        end
        x = 1'b0; #1;
        total++;
        if (z_ov !== 1'b0) begin
            bad++;
            $display("FAIL mealy_x0b z=%b expected 0", z_ov);
        end
        // Edge captured x=0 from S3 -> S0, so 0,0,1 must not match.
        drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        total++;
        if (z_ov !== 1'b0) begin
            bad++;
            $display("FAIL mealy_edge z=%b expected 0", z_ov);
        end
        $display("test_mealy_timing: toggled x in S3, post-edge z=%b", z_ov);
    endtask

    task automatic test_reset_mid();
        logic [3:0] tail;
        logic [3:0] exp_t;
        tail  = 4'b1001;
        exp_t = 4'b0001;
        pulse_reset();
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        pulse_reset();
        for (int i = 3; i >= 0; i--) begin
            drive_bit(tail[i]);
            total++;
            if (z_ov !== exp_t[i] || z_no !== exp_t[i]) begin
                bad++;
                $display("FAIL reset_mid step%0d z_ov=%b z_no=%b expected %b",
                         4 - i, z_ov, z_no, exp_t[i]);
            end
            $display("reset_mid step%0d x=%b z_ov=%b", 4 - i, tail[i], z_ov);
        end
    endtask

    task automatic test_self_loops();
        logic [5:0] s1;
        logic [5:0] e1;
        logic [4:0] s2;
        pulse_reset();
        s1 = 6'b111001;
        e1 = 6'b000001;
        for (int i = 5; i >= 0; i--) begin
            drive_bit(s1[i]);
            total++;
            if (z_ov !== e1[i] || z_no !== e1[i]) begin
                bad++;
                $display("FAIL loop_s1 bit%0d z_ov=%b z_no=%b expected %b", 6 - i, z_ov, z_no, e1[i]);
            end
            $display("loop_s1 bit%0d x=%b z_ov=%b", 6 - i, s1[i], z_ov);
        end
        pulse_reset();
        s2 = 5'b10001;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(s2[i]);
            total++;
            if (z_ov !== 1'b0 || z_no !== 1'b0) begin
                bad++;
                $display("FAIL loop_s3 bit%0d z_ov=%b z_no=%b expected 0", 5 - i, z_ov, z_no);
            end
            $display("loop_s3 bit%0d x=%b z_ov=%b", 5 - i, s2[i], z_ov);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        x     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_canonical();
        test_mealy_timing();
        test_reset_mid();
        test_self_loops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mealy_seq.md
Name: mealy_seq

Overview:
- Serial Mealy-type sequence detector: samples the 1-bit input x on each rising clock edge and searches for a fixed bit pattern.
- Output z is combinational on current state and current x. z pulses high during the cycle in which the final pattern bit is present on x, before that bit is clocked in.
- Default configuration detects "1001" (first-received bit first), with overlapping matches allowed.
- Leaf block for serial-stream pattern recognition. No handshake.

Parameters:
- N, 4, pattern length in bits (2..16).
- PATTERN, 4'b1001, pattern to detect; bit N-1 is the first bit received, bit 0 is the last.
- OVERLAP, 1, 1 = the suffix of a completed match may start the next match; 0 = state restarts from zero after a match.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
- x  input  1  serial data bit, sampled each rising edge.
- z  output  1  Mealy match flag; high while the current state plus current x completes PATTERN.

Behaviour:
- State: matched-prefix length k, 0..N-1. Width is clog2(N), min 1 bit.
- Default state names: S0 (nothing), S1 ("1"), S2 ("10"), S3 ("100").
- Reset: when reset==0 at a rising edge, state <= S0. While reset==0, z is forced to 0.
- Reset mid-sequence discards all partial progress.
- z = (reset==1) && (k==N-1) && (x==PATTERN[0]). Purely combinational, zero latency. It can change whenever x changes mid-cycle.
- General next state when x extends the prefix (x == PATTERN[N-1-k]):
  - If k < N-1: k+1.
  - If a match completes (k == N-1): with OVERLAP=1, next k = longest proper prefix of PATTERN that is also a suffix of the full pattern; with OVERLAP=0, next k = 0.
- General next state on mismatch: next k = longest prefix of PATTERN that is a suffix of (first k bits of PATTERN followed by x). This is the KMP failure rule.
- Compute the transition table at elaboration time with a constant function. No runtime table.
- Default transition table (state, x -> next state, z):
  - S0: x=0 -> S0, z=0; x=1 -> S1, z=0.
  - S1: x=0 -> S2, z=0; x=1 -> S1, z=0.
  - S2: x=0 -> S3, z=0; x=1 -> S1, z=0.
  - S3: x=0 -> S0, z=0; x=1 -> S1, z=1. Overlap: the trailing "1" is reused.
  - With OVERLAP=0, S3 with x=1 -> S0, z=1.
- No illegal states for N a power of 2. Otherwise unreachable encodings go to S0 on the next edge with z=0.
- z has no reset-independent glitch guarantee. Consumers sample z on the rising edge.

Decomposition:
- Shared package seq_det_pkg holds:
  - the constant function computing next-prefix length (pattern, N, k, x, overlap);
  - the clog2 helper;
  - the state typedef for the default 4-state case (S0..S3).
- No sub-module: single module with one state register plus combinational next-state/output logic.

Test Plan:
- Reset: hold reset=0 for 2 edges with x toggling -> z=0 throughout; state S0 after release.
- Canonical stream, x changing mid-cycle, one bit per cycle: 1,0,0,1,0,0,1,1,0,0,1,0,0.
  - z=1 exactly during the 4th, 7th and 11th bits; 0 elsewhere.
  - The 7th-bit match proves overlap reuse of the 4th bit.
- Same stream with OVERLAP=0 -> z=1 only on the 4th and 11th bits.
- Mealy timing: in state S3, toggle x 0->1->0 within one cycle -> z follows x combinationally with no edge; next state is decided by x at the edge.
- Reset mid-operation: feed 1,0,0, then reset=0 for one edge, release, feed 1 -> z=0; then 0,0,1 -> z=1 on that final 1.
- Self-loops: stream 1,1,1,0,0,1 -> z=1 only on the last bit (S1 self-loop). Stream 1,0,0,0,1 -> z=0 throughout (S3 with x=0 returns to S0).
